// File: rtl/rob_decoder_rx_pkg.sv
// Shared types for the Decoder->ROB packet channel: field types, word layouts,
// extraction helpers and the assembled dispatch entry.
package rob_decoder_rx_pkg;

  typedef logic [6:0]  RobIndex_T;
  typedef logic [7:0]  OperationId_T;
  typedef logic        Boolean_T;
  typedef logic [31:0] Data32_T;

  typedef struct packed {
    RobIndex_T    rob_index;
    logic [1:0]   rsvd_hi;
    Boolean_T     is_branch;
    Boolean_T     is_taken;
    logic [12:0]  rsvd_lo;
    OperationId_T op_id;
  } DecoderToRob1;

  typedef struct packed { Data32_T lower_imm; } DecoderToRob2;
  typedef struct packed { Data32_T upper_pc;  } DecoderToRob3;
  typedef struct packed { Data32_T lower_pc;  } DecoderToRob4;

  typedef struct packed {
    RobIndex_T    rob_index;
    Boolean_T     is_branch;
    Boolean_T     is_taken;
    OperationId_T op_id;
    Data32_T      imm;
    logic [63:0]  pc;
  } RobDispatchEntry;

  typedef enum logic [1:0] {W0, W1, W2, W3} RxWordIdx_T;

  function automatic DecoderToRob1 DecapDecoderToRob1(input Data32_T w);
    return DecoderToRob1'(w);
  endfunction

  function automatic DecoderToRob2 DecapDecoderToRob2(input Data32_T w);
    return DecoderToRob2'(w);
  endfunction

  function automatic DecoderToRob3 DecapDecoderToRob3(input Data32_T w);
    return DecoderToRob3'(w);
  endfunction

  function automatic DecoderToRob4 DecapDecoderToRob4(input Data32_T w);
    return DecoderToRob4'(w);
  endfunction

endpackage

// File: rtl/rob_decoder_rx.sv
// ROB input receive stage: assembles four decoder words into one dispatch
// entry held in a single output register, with reserved-bit and sequence checks.
module rob_decoder_rx
  import rob_decoder_rx_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_packet,
  output logic         entry_valid,
  input  logic         entry_ready,
  output logic [6:0]   entry_rob_index,
  output logic         entry_is_branch,
  output logic         entry_is_taken,
  output logic [7:0]   entry_op_id,
  output logic [31:0]  entry_imm,
  output logic [63:0]  entry_pc,
  output logic         err_rsvd,
  output logic         err_seq
);

  RxWordIdx_T      state, state_nx;
  DecoderToRob1    w0;
  DecoderToRob2    w1;
  DecoderToRob3    w2;
  DecoderToRob4    w3;
  RobDispatchEntry entry;

  RobIndex_T    stg_idx, last_idx;
  logic         stg_br, stg_tk;
  OperationId_T stg_op;
  Data32_T      stg_imm, stg_upc;
  logic         armed;
  logic         accept, rsvd_hit, seq_miss;

  assign w0 = DecapDecoderToRob1(in_packet);
  assign w1 = DecapDecoderToRob2(in_packet);
  assign w2 = DecapDecoderToRob3(in_packet);
  assign w3 = DecapDecoderToRob4(in_packet);

  // Only the final word can stall: it is the one that overwrites the held entry.
  assign in_ready = !flush && !(state == W3 && entry_valid && !entry_ready);
  assign accept   = in_valid && in_ready;
  assign rsvd_hit = (|w0.rsvd_hi) || (|w0.rsvd_lo);
  assign seq_miss = armed && (w0.rob_index != RobIndex_T'(last_idx + 7'd1));

  always_ff @(posedge clk) begin
    if (rst) state <= W0;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = W0;
    end else if (accept) begin
      unique case (state)
        W0: state_nx = W1;
        W1: state_nx = W2;
        W2: state_nx = W3;
        W3: state_nx = W0;
        default: state_nx = W0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_valid <= 1'b0;
      entry       <= '0;
      stg_idx     <= '0;
      stg_br      <= 1'b0;
      stg_tk      <= 1'b0;
      stg_op      <= '0;
      stg_imm     <= '0;
      stg_upc     <= '0;
      last_idx    <= '0;
      armed       <= 1'b0;
      err_rsvd    <= 1'b0;
      err_seq     <= 1'b0;
    end else if (flush) begin
      entry_valid <= 1'b0;
      armed       <= 1'b0;
    end else begin
      if (entry_ready) entry_valid <= 1'b0;
      if (accept) begin
        unique case (state)
          W0: begin
            stg_idx  <= w0.rob_index;
            stg_br   <= w0.is_branch;
            stg_tk   <= w0.is_taken;
            stg_op   <= w0.op_id;
            last_idx <= w0.rob_index;
            armed    <= 1'b1;
            if (rsvd_hit) err_rsvd <= 1'b1;
            if (seq_miss) err_seq  <= 1'b1;
          end
          W1: stg_imm <= w1.lower_imm;
          W2: stg_upc <= w2.upper_pc;
          W3: begin
            // Later assignment wins over the consume-clear: back-to-back entries, no bubble.
            entry.rob_index <= stg_idx;
            entry.is_branch <= stg_br;
            entry.is_taken  <= stg_tk;
            entry.op_id     <= stg_op;
            entry.imm       <= stg_imm;
            entry.pc        <= {stg_upc, w3.lower_pc};
            entry_valid     <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign entry_rob_index = entry.rob_index;
  assign entry_is_branch = entry.is_branch;
  assign entry_is_taken  = entry.is_taken;
  assign entry_op_id     = entry.op_id;
  assign entry_imm       = entry.imm;
  assign entry_pc        = entry.pc;

endmodule

// File: doc/rob_decoder_rx.md
# rob_decoder_rx

Receive stage at the Re-Order Buffer input for the 32-bit Decoder→ROB packet channel. It accepts the four-word DecoderToRob1..4 sequence one word per handshake, unpacks the fields, and assembles a full dispatch entry (ROB index, branch flags, operation id, immediate, 64-bit PC). The entry is presented to the ROB allocation logic through a one-entry output register with a valid/ready handshake. The block also checks reserved-bit and ROB-index sequencing rules.

## Interface
- No parameters. All widths come from the shared packages.
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- flush  in  1  abort: discard any partial sequence and any held entry
- in_valid  in  1  decoder word valid
- in_ready  out  1  block accepts word this cycle
- in_packet  in  32  packet word, interpreted by sequence position
- entry_valid  out  1  assembled entry held
- entry_ready  in  1  ROB takes the entry this cycle
- entry_rob_index  out  7  RobIndex_T, from word0[31:25]
- entry_is_branch  out  1  word0[22]
- entry_is_taken  out  1  word0[21]
- entry_op_id  out  8  OperationId_T, from word0[7:0]
- entry_imm  out  32  word1 (lowerImmediate)
- entry_pc  out  64  {word2 upperPC, word3 lowerPC}
- err_rsvd  out  1  sticky; reserved bits of word0 were non-zero
- err_seq  out  1  sticky; ROB index was not the expected successor

## Operation
- State machine: W0 → W1 → W2 → W3 → W0. The state advances only when a word is accepted (in_valid && in_ready).
- W0 captures robIndex, the branch flags and operationId into staging registers. W1 captures the immediate. W2 captures upperPC.
- In W3, an accepted word loads the output register from staging plus in_packet: entry_pc[31:0] = in_packet, entry_pc[63:32] = staged upperPC. It also sets entry_valid.
- in_ready = !(state==W3 && entry_valid && !entry_ready). Words 0–2 are accepted even while an entry is held. Only the final word stalls.
- entry_valid clears on entry_ready unless a new W3 word is accepted in the same cycle. In that case the new entry replaces the old one with no bubble.
- Data outputs hold their value while entry_valid=1. Once the entry is consumed they keep the last value; this is don't-care to the consumer.
- err_rsvd is set when a W0 word is accepted with word0[24:23] or word0[20:8] non-zero.
- err_seq is set when a W0 word is accepted with robIndex ≠ (last accepted robIndex + 1) mod 128.
  - The check is disabled for the first W0 after reset or flush.
  - Wrap-around: 127 → 0 is legal.
- In both error cases the entry is still assembled and forwarded. Both error flags clear only on rst.
- flush:
  - State returns to W0, entry_valid clears, and the sequence-check arm is disabled.
  - Any word presented in the flush cycle is ignored, and in_ready is forced to 0 that cycle.
  - flush has priority over both handshakes in the same cycle.
  - Error flags are preserved.

## Timing
- Reset values: state W0, entry_valid 0, all entry_* data 0, err_rsvd 0, err_seq 0, sequence check disarmed. in_ready reads 1 in the cycle after reset deasserts.
- Latency: entry_valid rises in the cycle after the W3 word is accepted.
- Peak throughput: one entry per 4 cycles with in_valid held high and entry_ready high.
- in_ready is combinational from state, entry_valid, entry_ready and flush. There is no combinational path from in_valid to in_ready.
- An error flag is visible in the cycle after the offending W0 word is accepted.
- rst mid-sequence discards the partial entry exactly as flush does, and additionally clears the error flags.

## Structure
- Type package (existing): RobIndex_T (7), OperationId_T (8), Boolean_T, Data32_T.
- Packet package additions:
  - RobDispatchEntry packed struct covering all entry_* fields.
  - RxWordIdx_T enum {W0, W1, W2, W3}.
  - Existing DecoderToRob1..4 structs and Decap* functions are used for field extraction.
- Single module; no sub-module is warranted. Staging registers plus the output register total about 150–200 lines.

## Test plan
- Basic entry: after reset, send 0x0460_0012, 0xDEAD_BEEF, 0x0000_0001, 0x8000_0000 back-to-back with entry_ready=1.
  - Expect entry_valid=1 on cycle 5 with rob_index=2, is_branch=1, is_taken=1, op_id=0x12, imm=0xDEADBEEF, pc=0x0000_0001_8000_0000.
  - Expect no errors.
- Backpressure: entry_ready=0 with two sequences streamed.
  - Words 0–2 of the second sequence are accepted. in_ready=0 in W3.
  - Raising entry_ready for one cycle hands off the first entry and accepts the second W3 word in that same cycle. The second entry appears the next cycle.
- Sequencing: ROB indices 126, 127, 0 → err_seq stays 0. Then index 5 → err_seq=1 one cycle later, and the entry is still delivered.
- Reserved bits: W0 word 0x0000_0100 (bit 8 set) → err_rsvd=1 and the entry is delivered with op_id=0x00.
- Flush: assert flush after W1 with entry_valid=1.
  - Next cycle: state W0, entry_valid=0.
  - A following full sequence with an arbitrary index gives err_seq=0.
- Reset mid-sequence: rst in W2 → all outputs at reset values. The next four words form a correct entry.
